// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register specifiers and
// processor status values used by the decode/writeback stage.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        STAT_RUN  = 2'b00,
        STAT_HALT = 2'b01,
        STAT_INS  = 2'b10
    } stat_t;

    function automatic logic [3:0] f_src_a(input logic [3:0] icode, input logic [3:0] ra);
        case (icode)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: f_src_a = ra;
            IRET, IPOPQ:                    f_src_a = RRSP;
            default:                        f_src_a = RNONE;
        endcase
    endfunction

    function automatic logic [3:0] f_src_b(input logic [3:0] icode, input logic [3:0] rb);
        case (icode)
            IRMMOVQ, IMRMOVQ, IOPQ:     f_src_b = rb;
            ICALL, IRET, IPUSHQ, IPOPQ: f_src_b = RRSP;
            default:                    f_src_b = RNONE;
        endcase
    endfunction

    // cmovXX only writes its destination when the condition held
    function automatic logic [3:0] f_dst_e(input logic [3:0] icode, input logic [3:0] rb,
                                           input logic cond);
        case (icode)
            IRRMOVQ:                    f_dst_e = cond ? rb : RNONE;
            IIRMOVQ, IOPQ:              f_dst_e = rb;
            ICALL, IRET, IPUSHQ, IPOPQ: f_dst_e = RRSP;
            default:                    f_dst_e = RNONE;
        endcase
    endfunction

    function automatic logic [3:0] f_dst_m(input logic [3:0] icode, input logic [3:0] ra);
        case (icode)
            IMRMOVQ, IPOPQ: f_dst_m = ra;
            default:        f_dst_m = RNONE;
        endcase
    endfunction

endpackage

// File: rtl/regfile_15x64.sv
// Fifteen 64-bit program registers with two combinational read ports and two
// write ports; index 4'hF reads as zero and is never written.
module regfile_15x64
    import y86_pkg::*;
#(
    parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_src_a,
    input  logic [3:0]  i_src_b,
    output logic [63:0] o_val_a,
    output logic [63:0] o_val_b,
    input  logic        i_we_e,
    input  logic [3:0]  i_dst_e,
    input  logic [63:0] i_val_e,
    input  logic        i_we_m,
    input  logic [3:0]  i_dst_m,
    input  logic [63:0] i_val_m
);

    logic [63:0] w_regs [16];

    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_reg
            logic [63:0] r_val_reg;

            // Port M is checked first so popq %rsp keeps the loaded value
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_val_reg <= (4'(gi) == RRSP) ? STACK_INIT : 64'd0;
                end else if (i_we_m && (i_dst_m == 4'(gi))) begin
                    r_val_reg <= i_val_m;
                end else if (i_we_e && (i_dst_e == 4'(gi))) begin
                    r_val_reg <= i_val_e;
                end
            end

            assign w_regs[gi] = r_val_reg;
        end
    endgenerate

    assign w_regs[15] = 64'd0;

    assign o_val_a = w_regs[i_src_a];
    assign o_val_b = w_regs[i_src_b];

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback stage: register operand decode, commit of valE/valM
// into the register file, and the sticky run/halt/invalid status machine.
module decode_writeback
    import y86_pkg::*;
#(
    parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cond,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [1:0]  stat
);

    stat_t       r_stat;
    logic [3:0]  w_src_a;
    logic [3:0]  w_src_b;
    logic [3:0]  w_dst_e;
    logic [3:0]  w_dst_m;
    logic        w_run;
    logic        w_valid_icode;
    logic        w_commit;

    always_comb begin
        w_src_a = f_src_a(icode, rA);
        w_src_b = f_src_b(icode, rB);
        w_dst_e = f_dst_e(icode, rB, cond);
        w_dst_m = f_dst_m(icode, rA);
    end

    assign w_run         = (r_stat == STAT_RUN);
    assign w_valid_icode = (icode != IHALT) && (icode <= IPOPQ);
    // The halting or faulting instruction itself retires without writing
    assign w_commit      = wb_en && w_run && w_valid_icode;

    regfile_15x64 #(
        .STACK_INIT (STACK_INIT)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_src_a (w_src_a),
        .i_src_b (w_src_b),
        .o_val_a (valA),
        .o_val_b (valB),
        .i_we_e  (w_commit),
        .i_dst_e (w_dst_e),
        .i_val_e (valE),
        .i_we_m  (w_commit),
        .i_dst_m (w_dst_m),
        .i_val_m (valM)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat <= STAT_RUN;
        end else begin
            case (r_stat)
                STAT_RUN: begin
                    if (wb_en) begin
                        if (icode == IHALT) begin
                            r_stat <= STAT_HALT;
                        end else if (icode > IPOPQ) begin
                            r_stat <= STAT_INS;
                        end
                    end
                end
                default: r_stat <= r_stat;
            endcase
        end
    end

    assign stat = r_stat;

endmodule

// File: tb/tb_decode_writeback.sv
// Vector-table bench for decode_writeback: each row drives one cycle and the
// expected read data / status for that cycle travels through a scoreboard queue.
module tb_decode_writeback;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cond;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [1:0]  stat;

    int checks_total;
    int checks_passed;

    decode_writeback #(
        .STACK_INIT (64'h0000_0000_0000_0200)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wb_en (wb_en),
        .icode (icode),
        .rA    (rA),
        .rB    (rB),
        .cond  (cond),
        .valE  (valE),
        .valM  (valM),
        .valA  (valA),
        .valB  (valB),
        .stat  (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        wb;
        logic [3:0]  icode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        cond;
        logic [63:0] vale;
        logic [63:0] valm;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        logic [1:0]  exp_stat;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  st;
    } exp_t;

    vec_t vecs [27];
    exp_t sb_q [$];

    function automatic vec_t mk(input string n, input logic r, input logic w, input logic [3:0] ic,
                                input logic [3:0] a, input logic [3:0] b, input logic c,
                                input logic [63:0] e, input logic [63:0] m, input logic [63:0] xa,
                                input logic [63:0] xb, input logic [1:0] xs);
        vec_t v;
        v.name = n; v.rst = r; v.wb = w; v.icode = ic; v.ra = a; v.rb = b; v.cond = c;
        v.vale = e; v.valm = m; v.exp_a = xa; v.exp_b = xb; v.exp_stat = xs;
        return v;
    endfunction

    task automatic drive(input logic r, input logic w, input logic [3:0] ic, input logic [3:0] a,
                         input logic [3:0] b, input logic c, input logic [63:0] e, input logic [63:0] m);
        rst = r; wb_en = w; icode = ic; rA = a; rB = b; cond = c; valE = e; valM = m;
    endtask

    task automatic check_cycle();
        exp_t x;
        if (sb_q.size() == 0) begin
            checks_total++;
            $display("FAIL scoreboard_empty actual=0 entries required=1");
            return;
        end
        x = sb_q.pop_front();
        checks_total++;
        if (valA === x.a) checks_passed++;
        else $display("FAIL %s.valA actual=%h required=%h", x.name, valA, x.a);
        checks_total++;
        if (valB === x.b) checks_passed++;
        else $display("FAIL %s.valB actual=%h required=%h", x.name, valB, x.b);
        checks_total++;
        if (stat === x.st) checks_passed++;
        else $display("FAIL %s.stat actual=%b required=%b", x.name, stat, x.st);
        $display("%s: valA=%h valB=%h stat=%b", x.name, valA, valB, stat);
    endtask

    initial begin
        vecs[0]  = mk("reset_read",   0, 0, 4'hB, 4'hF, 4'hF, 0, 64'h0,    64'h0,    64'h200,  64'h200,  2'b00);
        vecs[1]  = mk("irmovq_r2",    0, 1, 4'h3, 4'hF, 4'h2, 0, 64'h5,    64'h0,    64'h0,    64'h0,    2'b00);
        vecs[2]  = mk("opq_read",     0, 0, 4'h6, 4'h2, 4'h2, 0, 64'h0,    64'h0,    64'h5,    64'h5,    2'b00);
        vecs[3]  = mk("opq_wr_old",   0, 1, 4'h6, 4'h6, 4'h6, 0, 64'h11,   64'h0,    64'h0,    64'h0,    2'b00);
        vecs[4]  = mk("opq_wr_new",   0, 0, 4'h6, 4'h6, 4'h6, 0, 64'h0,    64'h0,    64'h11,   64'h11,   2'b00);
        vecs[5]  = mk("cmov_c0",      0, 1, 4'h2, 4'h1, 4'h3, 0, 64'h7,    64'h0,    64'h0,    64'h0,    2'b00);
        vecs[6]  = mk("cmov_c0_rd",   0, 0, 4'h6, 4'h3, 4'h1, 0, 64'h0,    64'h0,    64'h0,    64'h0,    2'b00);
        vecs[7]  = mk("cmov_c1",      0, 1, 4'h2, 4'h1, 4'h3, 1, 64'h7,    64'h0,    64'h0,    64'h0,    2'b00);
        vecs[8]  = mk("cmov_c1_rd",   0, 0, 4'h6, 4'h3, 4'h2, 0, 64'h0,    64'h0,    64'h7,    64'h5,    2'b00);
        vecs[9]  = mk("popq_rsp",     0, 1, 4'hB, 4'h4, 4'hF, 0, 64'h208,  64'hDEAD, 64'h200,  64'h200,  2'b00);
        vecs[10] = mk("popq_rsp_rd",  0, 0, 4'hB, 4'hF, 4'hF, 0, 64'h0,    64'h0,    64'hDEAD, 64'hDEAD, 2'b00);
        vecs[11] = mk("popq_r7",      0, 1, 4'hB, 4'h7, 4'hF, 0, 64'h1000, 64'h77,   64'hDEAD, 64'hDEAD, 2'b00);
        vecs[12] = mk("popq_r7_rd",   0, 0, 4'h6, 4'h7, 4'h4, 0, 64'h0,    64'h0,    64'h77,   64'h1000, 2'b00);
        vecs[13] = mk("mrmovq_r8",    0, 1, 4'h5, 4'h8, 4'h7, 0, 64'h99,   64'hABCD, 64'h0,    64'h77,   2'b00);
        vecs[14] = mk("mrmovq_rd",    0, 0, 4'h6, 4'h8, 4'h9, 0, 64'h0,    64'h0,    64'hABCD, 64'h0,    2'b00);
        vecs[15] = mk("halt",         0, 1, 4'h0, 4'hF, 4'hF, 0, 64'h0,    64'h0,    64'h0,    64'h0,    2'b00);
        vecs[16] = mk("after_halt",   0, 1, 4'h3, 4'hF, 4'h1, 0, 64'h9,    64'h0,    64'h0,    64'h0,    2'b01);
        vecs[17] = mk("halt_r1_rd",   0, 0, 4'h6, 4'h1, 4'h0, 0, 64'h0,    64'h0,    64'h0,    64'h0,    2'b01);
        vecs[18] = mk("halt_reset",   1, 0, 4'h1, 4'hF, 4'hF, 0, 64'h0,    64'h0,    64'h0,    64'h0,    2'b01);
        vecs[19] = mk("rst_rd_78",    0, 0, 4'h6, 4'h7, 4'h8, 0, 64'h0,    64'h0,    64'h0,    64'h0,    2'b00);
        vecs[20] = mk("rst_rd_rsp",   0, 0, 4'hB, 4'hF, 4'hF, 0, 64'h0,    64'h0,    64'h200,  64'h200,  2'b00);
        vecs[21] = mk("ins_c",        0, 1, 4'hC, 4'h1, 4'h2, 0, 64'h55,   64'h66,   64'h0,    64'h0,    2'b00);
        vecs[22] = mk("ins_ignored",  0, 1, 4'h6, 4'h1, 4'h2, 0, 64'h3,    64'h0,    64'h0,    64'h0,    2'b10);
        vecs[23] = mk("ins_rd",       0, 0, 4'h6, 4'h1, 4'h2, 0, 64'h0,    64'h0,    64'h0,    64'h0,    2'b10);
        vecs[24] = mk("ins_reset",    1, 0, 4'h1, 4'hF, 4'hF, 0, 64'h0,    64'h0,    64'h0,    64'h0,    2'b10);
        vecs[25] = mk("irmovq_r5",    0, 1, 4'h3, 4'hF, 4'h5, 0, 64'h55,   64'h0,    64'h0,    64'h0,    2'b00);
        vecs[26] = mk("r5_rd",        0, 0, 4'h6, 4'h5, 4'h4, 0, 64'h0,    64'h0,    64'h55,   64'h200,  2'b00);
    end

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        drive(1, 0, 4'h1, 4'hF, 4'hF, 0, 64'h0, 64'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].rst, vecs[i].wb, vecs[i].icode, vecs[i].ra, vecs[i].rb,
                  vecs[i].cond, vecs[i].vale, vecs[i].valm);
            sb_q.push_back('{vecs[i].name, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_stat});
            #2;
            check_cycle();
            @(posedge clk);
            #1;
        end

        // Reset colliding with a live commit: reset must win
        drive(1, 1, 4'h3, 4'hF, 4'h5, 0, 64'h99, 64'h0);
        sb_q.push_back('{"rst_vs_wb", 64'h0, 64'h0, 2'b00});
        #2;
        check_cycle();
        @(posedge clk);
        #1;

        // Full sweep of the reset image through both read ports
        for (int r = 0; r < 15; r++) begin
            logic [3:0]  ia;
            logic [3:0]  ib;
            logic [63:0] ea;
            logic [63:0] eb;
            ia = 4'(r);
            ib = 4'(14 - r);
            ea = (r == 4) ? 64'h200 : 64'h0;
            eb = ((14 - r) == 4) ? 64'h200 : 64'h0;
            drive(0, 0, 4'h6, ia, ib, 0, 64'h0, 64'h0);
            sb_q.push_back('{$sformatf("sweep_r%0d", r), ea, eb, 2'b00});
            #2;
            check_cycle();
            @(posedge clk);
            #1;
        end

        drive(0, 0, 4'h6, 4'hF, 4'hF, 0, 64'h0, 64'h0);
        sb_q.push_back('{"rnone_rd", 64'h0, 64'h0, 2'b00});
        #2;
        check_cycle();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
